// File: rtl/mdv_pkg.sv
// mdv_pkg: shared constants, FSM states and slot addressing for the microdrive controller
//   BASE_ADDR  word address of slot 0
//   SLOT_BITS  log2 of the slot size in words
//   slot_base  base word address of a slot index
package mdv_pkg;
    localparam logic [24:0] BASE_ADDR = 25'h800000;
    localparam int SLOT_BITS = 17;
    typedef enum logic [1:0] {IDLE = 2'd0, SPINUP = 2'd1, RUN = 2'd2, SAVE = 2'd3} mdv_state_t;
    function automatic logic [24:0] slot_base(input logic [2:0] idx, input logic [24:0] base = BASE_ADDR,
                                              input int bits = SLOT_BITS);
        return base + (25'(idx) << bits);
    endfunction
endpackage

// File: rtl/mdv_sel_shift.sv
// mdv_sel_shift: ZX8302 drive-select shift receiver with one-hot decode
//   mdv_clk, reset        controller clock, async active-high reset
//   sel_clk, sel_data     raw select shift clock/data, synchronised here
//   dec                   one-hot request, 0 when none or several bits set
//   req_idx, req_valid    index of the single set bit and its validity
//   sel_err               more than one select bit set
module mdv_sel_shift #(
    parameter int NUM_DRIVES = 2
) (
    input  logic                  mdv_clk,
    input  logic                  reset,
    input  logic                  sel_clk,
    input  logic                  sel_data,
    output logic [NUM_DRIVES-1:0] dec,
    output logic [2:0]            req_idx,
    output logic                  req_valid,
    output logic                  sel_err
);
    logic [1:0] clk_s, dat_s;
    logic clk_d;
    logic [NUM_DRIVES-1:0] shreg, shreg_nx;
    always_ff @(posedge mdv_clk or posedge reset)
        if (reset) begin
            clk_s <= '0;
            dat_s <= '0;
            clk_d <= 1'b0;
            shreg <= '0;
        end else begin
            clk_s <= {clk_s[0], sel_clk};
            dat_s <= {dat_s[0], sel_data};
            clk_d <= clk_s[1];
            if (clk_s[1] && !clk_d) shreg <= shreg_nx;
        end
    if (NUM_DRIVES == 1) begin : g_one
        assign shreg_nx = dat_s[1];
    end else begin : g_many
        assign shreg_nx = {shreg[NUM_DRIVES-2:0], dat_s[1]};
    end
    assign sel_err   = (shreg & (shreg - NUM_DRIVES'(1))) != '0;
    assign req_valid = shreg != '0 && !sel_err;
    assign dec       = req_valid ? shreg : '0;
    always_comb begin
        req_idx = '0;
        for (int i = 0; i < NUM_DRIVES; i++) if (shreg[i]) req_idx = 3'(i);
    end
endmodule

// File: rtl/mdv_drive_ctrl.sv
// mdv_drive_ctrl: microdrive select decode, motor spin-up and per-drive position save/restore
//   mdv_clk, reset             controller clock, async active-high reset
//   sel_clk, sel_data          raw ZX8302 select shift lines
//   dl_done, dl_slot, dl_len   image download finished into a slot (len 0 = empty)
//   eng_pos_cur                replay engine's current word offset
//   drive_sel, motor_on        one-hot selected drive and motor enable
//   no_media, sel_err          selected slot empty / several select bits set
//   eng_run, eng_base, eng_len replay engine enable and active slot geometry
//   eng_pos_load, eng_pos      start-offset load strobe and restored offset
module mdv_drive_ctrl #(
    parameter int          NUM_DRIVES  = 2,
    parameter logic [24:0] BASE_ADDR   = mdv_pkg::BASE_ADDR,
    parameter int          SLOT_BITS   = mdv_pkg::SLOT_BITS,
    parameter int          SPINUP_BITS = 12000
) (
    input  logic                  mdv_clk,
    input  logic                  reset,
    input  logic                  sel_clk,
    input  logic                  sel_data,
    input  logic                  dl_done,
    input  logic [2:0]            dl_slot,
    input  logic [SLOT_BITS-1:0]  dl_len,
    input  logic [SLOT_BITS-1:0]  eng_pos_cur,
    output logic [NUM_DRIVES-1:0] drive_sel,
    output logic                  motor_on,
    output logic                  no_media,
    output logic                  eng_run,
    output logic [24:0]           eng_base,
    output logic [SLOT_BITS-1:0]  eng_len,
    output logic                  eng_pos_load,
    output logic [SLOT_BITS-1:0]  eng_pos,
    output logic                  sel_err
);
    import mdv_pkg::*;
    localparam int SW = SPINUP_BITS > 1 ? $clog2(SPINUP_BITS) : 1;
    mdv_state_t state;
    logic [SW-1:0] spin;
    logic [2:0] cur, sel_idx, req_idx;
    logic [SLOT_BITS-1:0] len_r [8];
    logic [SLOT_BITS-1:0] pos_r [8];
    logic [NUM_DRIVES-1:0] dec;
    logic req_valid, req_same, dl_ok, dl_abort;
    mdv_sel_shift #(.NUM_DRIVES(NUM_DRIVES)) u_sel (
        .mdv_clk   (mdv_clk),
        .reset     (reset),
        .sel_clk   (sel_clk),
        .sel_data  (sel_data),
        .dec       (dec),
        .req_idx   (req_idx),
        .req_valid (req_valid),
        .sel_err   (sel_err)
    );
    assign dl_ok    = dl_done && int'(dl_slot) < NUM_DRIVES;
    assign dl_abort = dl_ok && dl_slot == cur && (state == SPINUP || state == RUN);
    assign req_same = req_valid && req_idx == cur;
    assign motor_on = drive_sel != '0;
    assign no_media = motor_on && len_r[sel_idx] == '0;
    always_ff @(posedge mdv_clk or posedge reset)
        if (reset) begin
            state        <= IDLE;
            spin         <= '0;
            cur          <= '0;
            sel_idx      <= '0;
            drive_sel    <= '0;
            eng_run      <= 1'b0;
            eng_base     <= BASE_ADDR;
            eng_len      <= '0;
            eng_pos_load <= 1'b0;
            eng_pos      <= '0;
            for (int i = 0; i < 8; i++) begin
                len_r[i] <= '0;
                pos_r[i] <= '0;
            end
        end else begin
            drive_sel    <= dec;
            sel_idx      <= req_idx;
            eng_pos_load <= 1'b0;
            if (dl_ok) begin
                len_r[dl_slot] <= dl_len;
                pos_r[dl_slot] <= '0;
                if (dl_abort) begin
                    eng_run <= 1'b0;
                    state   <= IDLE;
                end
            end else
                case (state)
                    IDLE:
                        if (req_valid && len_r[req_idx] != '0) begin
                            cur          <= req_idx;
                            eng_base     <= slot_base(req_idx, BASE_ADDR, SLOT_BITS);
                            eng_len      <= len_r[req_idx];
                            eng_pos      <= pos_r[req_idx];
                            eng_pos_load <= 1'b1;
                            spin         <= SW'(SPINUP_BITS - 1);
                            state        <= SPINUP;
                        end
                    SPINUP:
                        if (!req_same) state <= IDLE;
                        else if (spin == '0) begin
                            eng_run <= 1'b1;
                            state   <= RUN;
                        end else spin <= spin - SW'(1);
                    RUN:
                        if (!req_same) begin
                            eng_run <= 1'b0;
                            state   <= SAVE;
                        end
                    SAVE: begin
                        pos_r[cur] <= eng_pos_cur >= len_r[cur] ? '0 : eng_pos_cur;
                        state      <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
        end
endmodule
